uart_tx_arbiter: RTL

//  Shares one UART transmitter byte port (8-bit DataIn/Valid/Ready) among NumReq

---
 rtl/uart_tx_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter for a shared UART tx byte port
// The owner keeps the line until its Last byte is accepted or it stalls past the timeout.
module uart_tx_arbiter #(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 65536
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NumReq*8-1:0] ReqData,
  input  logic [NumReq-1:0]   ReqValid,
  input  logic [NumReq-1:0]   ReqLast,
  output logic [NumReq-1:0]   ReqReady,
  output logic [7:0]          DataIn,
  output logic                DataInValid,
  input  logic                DataInReady,
  output logic [NumReq-1:0]   Grant,
  output logic                Busy,
  output logic                TimeoutPulse
);

  localparam int TimerWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) + 1 : 1;
  localparam int PtrWidth   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [TimerWidth-1:0] TimerLast =
    (TimeoutCycles > 0) ? TimerWidth'(TimeoutCycles - 1) : '0;
  localparam logic [PtrWidth-1:0] PtrReset = PtrWidth'(NumReq - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_next;
  logic [PtrWidth-1:0]   ptr, ptr_next, pick;
  logic                  pick_found;
  logic [TimerWidth-1:0] timer, timer_next;
  logic                  valid_g, last_g, handshake;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      ptr   <= PtrReset;
      timer <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      timer <= timer_next;
    end
  end

  // Scan starts one past the last owner so it ends up with lowest priority.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = ptr;
    pick_found = 1'b0;
    for (int k = 1; k <= NumReq; k++) begin
      idx = (int'(ptr) + k) % NumReq;
      if (!pick_found && ReqValid[idx[PtrWidth-1:0]]) begin
        pick       = idx[PtrWidth-1:0];
        pick_found = 1'b1;
      end
    end
  end

  assign Busy      = (state == GRANT);
  assign valid_g   = ReqValid[ptr];
  assign last_g    = ReqLast[ptr];
  assign handshake = Busy && valid_g && DataInReady;

  assign Grant       = Busy ? (NumReq'(1'b1) << ptr) : '0;
  assign ReqReady    = Busy ? (NumReq'(DataInReady) << ptr) : '0;
  assign DataIn      = Busy ? ReqData[{ptr, 3'b000} +: 8] : 8'h00;
  assign DataInValid = Busy && valid_g;

  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    timer_next   = timer;
    TimeoutPulse = 1'b0;
    case (state)
      IDLE: begin
        timer_next = '0;
        if (pick_found) begin
          state_next = GRANT;
          ptr_next   = pick;
        end
      end
      GRANT: begin
        if (handshake) begin
          timer_next = '0;
          if (last_g) state_next = IDLE;
        end else if (!valid_g && TimeoutCycles != 0) begin
          // Only owner silence counts; transmitter backpressure never expires.
          if (timer == TimerLast) begin
            TimeoutPulse = 1'b1;
            state_next   = IDLE;
            timer_next   = '0;
          end else begin
            timer_next = timer + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
